// File: rtl/apb_master_arbiter_if.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter_if
// Bundles the requester-side handshake and the APB3 master bus of
// apb_master_arbiter.
//   master modport : the arbiter's view. It takes in requests and the
//                    slave response, and drives grants, completions and
//                    the APB controls.
//   slave modport  : the opposite view, used by requesters and the APB
//                    slave (or a bench).
// Requester i uses slice i of req_addr/req_wdata.
// ---------------------------------------------------------------------------
interface apb_master_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_err;
    logic                          busy;
    logic                          PSELx;
    logic                          PENABLE;
    logic                          PWRITE;
    logic [ADDR_WIDTH-1:0]         PADDR;
    logic [DATA_WIDTH-1:0]         PWDATA;
    logic [DATA_WIDTH-1:0]         PRDATA;
    logic                          PREADY;
    logic                          PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter
// Shares one APB3 master port among NUM_REQ requesters. Arbitration is
// round-robin. The block sequences the SETUP/ACCESS phases, returns read
// data or error to the owner, and forces an error completion after
// WAIT_LIMIT wait states (WAIT_LIMIT=0 disables the timeout).
// Ports:
//   PCLK    : bus clock, rising edge
//   PRESETn : asynchronous active-low reset
//   bus     : apb_master_arbiter_if.master. It carries the requester
//             handshake (req_*/rsp_*), busy, and the APB signals.
// Every output is a flop.
// ---------------------------------------------------------------------------
module apb_master_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int WAIT_LIMIT = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_master_arbiter_if.master bus
);
    localparam int            PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int            CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [PW:0]   NR = (PW+1)'(NUM_REQ);
    localparam logic [CW:0]   WL = (CW+1)'(WAIT_LIMIT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                r_state, w_state;
    logic [PW-1:0]         r_ptr, w_ptr, r_owner, w_owner;
    logic [CW-1:0]         r_cnt, w_cnt;
    logic                  r_psel, w_psel, r_penable, w_penable, r_pwrite, w_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr, w_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata, r_rdata, w_rdata;
    logic [NUM_REQ-1:0]    r_req_ready, w_req_ready, r_rsp_valid, w_rsp_valid;
    logic                  r_err, w_err;

    logic [NUM_REQ-1:0]    w_cand;
    logic                  w_found;
    logic [PW-1:0]         w_win, w_ptr_adv;
    logic [PW:0]           w_idx;
    logic [CW:0]           w_cnt_inc;
    logic                  w_timeout;
    logic                  w_free;

    // Round-robin pick. The owner is masked while its transfer is in ACCESS.
    // A request it still holds at its own completion edge therefore only
    // counts as a new transfer after rsp_valid has been issued.
    always_comb begin
        w_cand  = bus.req_valid;
        if (r_state == ACCESS) w_cand[r_owner] = 1'b0;
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_idx >= NR) w_idx = w_idx - NR;
            if (!w_found && w_cand[w_idx[PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[PW-1:0];
            end
        end
        w_ptr_adv = ({1'b0, w_win} == NR - 1'b1) ? '0 : w_win + 1'b1;
    end

    assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
    assign w_timeout = (WAIT_LIMIT != 0) && (w_cnt_inc == WL);

    always_comb begin
        w_state     = r_state;
        w_ptr       = r_ptr;
        w_owner     = r_owner;
        w_cnt       = r_cnt;
        w_psel      = r_psel;
        w_penable   = r_penable;
        w_pwrite    = r_pwrite;
        w_paddr     = r_paddr;
        w_pwdata    = r_pwdata;
        w_req_ready = '0;
        w_rsp_valid = '0;
        w_rdata     = '0;
        w_err       = 1'b0;
        w_free      = 1'b0;
        case (r_state)
            IDLE: w_free = 1'b1;
            SETUP: begin
                w_state   = ACCESS;
                w_penable = 1'b1;
                w_cnt     = '0;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    w_rsp_valid[r_owner] = 1'b1;
                    w_err                = bus.PSLVERR;
                    w_rdata              = r_pwrite ? '0 : bus.PRDATA;
                    w_free               = 1'b1;
                end else if (w_timeout) begin
                    w_rsp_valid[r_owner] = 1'b1;
                    w_err                = 1'b1;
                    w_free               = 1'b1;
                end else begin
                    w_cnt = w_cnt_inc[CW-1:0];
                end
                if (w_free) begin
                    w_state   = IDLE;
                    w_psel    = 1'b0;
                    w_penable = 1'b0;
                end
            end
            default: w_state = IDLE;
        endcase
        // A grant can land on the completion edge. That makes back-to-back
        // transfers with PSELx held high.
        if (w_free && w_found) begin
            w_state            = SETUP;
            w_psel             = 1'b1;
            w_penable          = 1'b0;
            w_pwrite           = bus.req_write[w_win];
            w_paddr            = bus.req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
            w_pwdata           = bus.req_wdata[w_win*DATA_WIDTH +: DATA_WIDTH];
            w_req_ready[w_win] = 1'b1;
            w_owner            = w_win;
            w_ptr              = w_ptr_adv;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_cnt       <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_ptr       <= w_ptr;
            r_owner     <= w_owner;
            r_cnt       <= w_cnt;
            r_psel      <= w_psel;
            r_penable   <= w_penable;
            r_pwrite    <= w_pwrite;
            r_paddr     <= w_paddr;
            r_pwdata    <= w_pwdata;
            r_req_ready <= w_req_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rdata     <= w_rdata;
            r_err       <= w_err;
        end
    end

    assign bus.PSELx     = r_psel;
    assign bus.busy      = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;
    localparam int NR = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int WL = 16;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;
    always #5 PCLK = ~PCLK;

    apb_master_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    apb_master_arbiter_if #(.NUM_REQ(2),  .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();

    apb_master_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_LIMIT(WL)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus.master));
    apb_master_arbiter #(.NUM_REQ(2), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_LIMIT(0)) dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus0.master));

    int vectors     = 0;
    int miscompares = 0;

    task automatic drive_req(int i, logic v, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
        bus.req_valid[i]         = v;
        bus.req_write[i]         = w;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    // Reference round-robin: first set bit at or above p, wrapping.
    function automatic int rr_pick(int p, logic [NR-1:0] e);
        for (int k = 0; k < NR; k++) if (e[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    task automatic test_reset();
        PRESETn = 1'b0;
        repeat (2) @(negedge PCLK);
        vectors++;
        if ({bus.PSELx, bus.PENABLE, bus.PWRITE, bus.busy, bus.rsp_err} !== 5'b0) begin
            miscompares++; $display("FAIL reset_ctrl: got %b expected 00000",
                {bus.PSELx, bus.PENABLE, bus.PWRITE, bus.busy, bus.rsp_err});
        end
        vectors++;
        if ({bus.req_ready, bus.rsp_valid} !== '0) begin
            miscompares++; $display("FAIL reset_hs: got %b expected 0", {bus.req_ready, bus.rsp_valid});
        end
        vectors++;
        if ({bus.PADDR, bus.PWDATA, bus.rsp_rdata} !== '0) begin
            miscompares++; $display("FAIL reset_data: got %h %h %h expected 0", bus.PADDR, bus.PWDATA, bus.rsp_rdata);
        end
        PRESETn = 1'b1;
    endtask

    task automatic test_single_write();
        @(negedge PCLK);
        drive_req(0, 1'b1, 1'b1, 32'h0000_0004, 32'hA5A5_0001);
        bus.PREADY = 1'b1; bus.PRDATA = 32'hDEAD_BEEF; bus.PSLVERR = 1'b0;
        @(posedge PCLK); #1;
        vectors++;
        if ({bus.req_ready, bus.PSELx, bus.PENABLE, bus.PWRITE, bus.busy} !== {3'b001, 4'b1011}) begin
            miscompares++; $display("FAIL wr_setup_ctrl: got %b expected 0011011",
                {bus.req_ready, bus.PSELx, bus.PENABLE, bus.PWRITE, bus.busy});
        end
        vectors++;
        if ({bus.PADDR, bus.PWDATA} !== {32'h4, 32'hA5A5_0001}) begin
            miscompares++; $display("FAIL wr_setup_data: got %h %h expected 4 a5a50001", bus.PADDR, bus.PWDATA);
        end
        @(negedge PCLK); bus.req_valid = '0;
        @(posedge PCLK); #1;
        vectors++;
        if ({bus.req_ready, bus.rsp_valid, bus.PSELx, bus.PENABLE} !== 8'b000_000_11) begin
            miscompares++; $display("FAIL wr_access: got %b expected 00000011",
                {bus.req_ready, bus.rsp_valid, bus.PSELx, bus.PENABLE});
        end
        @(posedge PCLK); #1;
        vectors++;
        if ({bus.rsp_valid, bus.rsp_err, bus.PSELx, bus.PENABLE, bus.busy} !== 7'b001_0000) begin
            miscompares++; $display("FAIL wr_done: got %b expected 0010000",
                {bus.rsp_valid, bus.rsp_err, bus.PSELx, bus.PENABLE, bus.busy});
        end
        vectors++;
        if ({bus.rsp_rdata, bus.PADDR} !== {32'h0, 32'h4}) begin
            miscompares++; $display("FAIL wr_done_data: got %h %h expected 0 4", bus.rsp_rdata, bus.PADDR);
        end
    endtask

    task automatic test_read_waits();
        int lat = -1;
        logic [NR-1:0] rv = '0;
        logic [DW-1:0] rd = '0;
        logic er = 1'b0;
        @(negedge PCLK);
        drive_req(1, 1'b1, 1'b0, 32'h8, 32'h0);
        bus.PREADY = 1'b0;
        @(posedge PCLK); #1;
        vectors++;
        if (bus.req_ready !== 3'b010) begin
            miscompares++; $display("FAIL rd_grant: got %b expected 010", bus.req_ready);
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge PCLK);
            bus.req_valid = '0;
            bus.PREADY  = (k >= 5);
            bus.PSLVERR = (k < 5);
            bus.PRDATA  = (k >= 5) ? 32'h1234_5678 : (32'hBAD0_0000 | 32'(k));
            @(posedge PCLK); #1;
            if (bus.rsp_valid !== '0) begin
                lat = k; rv = bus.rsp_valid; rd = bus.rsp_rdata; er = bus.rsp_err;
                break;
            end
        end
        bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
        vectors++;
        if (lat !== 5) begin
            miscompares++; $display("FAIL rd_latency: got %0d expected 5", lat);
        end
        vectors++;
        if ({rv, er, rd} !== {3'b010, 1'b0, 32'h1234_5678}) begin
            miscompares++; $display("FAIL rd_resp: got %b %b %h expected 010 0 12345678", rv, er, rd);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_rr, exp_rv;
        logic [AW-1:0] exp_a;
        for (int k = 0; k <= 8; k++) begin
            @(negedge PCLK);
            drive_req(0, k <= 6, 1'b1, 32'h100, 32'h1000 + 32'(k));
            drive_req(1, k <= 6, 1'b0, 32'h200, 32'h2000 + 32'(k));
            @(posedge PCLK); #1;
            exp_rr = ((k % 2 == 0) && k <= 6) ? (3'b001 << ((k / 2) % 2)) : 3'b000;
            exp_rv = ((k % 2 == 0) && k >= 2) ? (3'b001 << ((k / 2 - 1) % 2)) : 3'b000;
            vectors++;
            if ({bus.req_ready, bus.rsp_valid} !== {exp_rr, exp_rv}) begin
                miscompares++; $display("FAIL rr_hs_%0d: got %b %b expected %b %b",
                    k, bus.req_ready, bus.rsp_valid, exp_rr, exp_rv);
            end
            vectors++;
            if ({bus.PSELx, bus.PENABLE} !== {k <= 7, k % 2 == 1}) begin
                miscompares++; $display("FAIL rr_bus_%0d: got %b%b expected %b%b",
                    k, bus.PSELx, bus.PENABLE, k <= 7, k % 2 == 1);
            end
            if (exp_rr !== '0) begin
                exp_a = exp_rr[0] ? 32'h100 : 32'h200;
                vectors++;
                if (bus.PADDR !== exp_a) begin
                    miscompares++; $display("FAIL rr_addr_%0d: got %h expected %h", k, bus.PADDR, exp_a);
                end
            end
        end
    endtask

    task automatic test_slave_error();
        int lat = -1;
        logic [NR-1:0] rv = '0;
        logic er = 1'b0;
        @(negedge PCLK);
        drive_req(0, 1'b1, 1'b1, 32'h10, 32'h5555_AAAA);
        @(posedge PCLK); #1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge PCLK);
            bus.req_valid = '0;
            bus.PREADY = (k >= 3); bus.PSLVERR = 1'b1;
            @(posedge PCLK); #1;
            if (bus.rsp_valid !== '0) begin
                lat = k; rv = bus.rsp_valid; er = bus.rsp_err;
                break;
            end
        end
        bus.PSLVERR = 1'b0; bus.PREADY = 1'b1;
        vectors++;
        if ({lat == 3, rv, er} !== {1'b1, 3'b001, 1'b1}) begin
            miscompares++; $display("FAIL slverr: got lat %0d rv %b err %b expected lat 3 rv 001 err 1", lat, rv, er);
        end
    endtask

    task automatic test_timeout();
        int lat = -1;
        logic [NR-1:0] rv = '0;
        logic er = 1'b0;
        logic [DW-1:0] rd = '1;
        logic [2:0] ctl = '1;
        logic psel_dropped = 1'b0;
        @(negedge PCLK);
        drive_req(2, 1'b1, 1'b0, 32'hC, 32'h0);
        bus.PREADY = 1'b0; bus.PRDATA = 32'hFFFF_FFFF;
        @(posedge PCLK); #1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge PCLK);
            bus.req_valid = '0;
            @(posedge PCLK); #1;
            if (bus.rsp_valid !== '0) begin
                lat = k; rv = bus.rsp_valid; er = bus.rsp_err; rd = bus.rsp_rdata;
                ctl = {bus.PSELx, bus.PENABLE, bus.busy};
                break;
            end
            if (bus.PSELx !== 1'b1) psel_dropped = 1'b1;
        end
        bus.PREADY = 1'b1;
        vectors++;
        if (lat !== WL + 1) begin
            miscompares++; $display("FAIL tmo_latency: got %0d expected %0d", lat, WL + 1);
        end
        vectors++;
        if ({rv, er, rd, ctl, psel_dropped} !== {3'b100, 1'b1, 32'h0, 3'b000, 1'b0}) begin
            miscompares++; $display("FAIL tmo_resp: got rv %b err %b rdata %h ctl %b drop %b expected 100 1 0 000 0",
                rv, er, rd, ctl, psel_dropped);
        end
    endtask

    task automatic test_no_timeout();
        int rsp_seen = 0;
        int bus_bad  = 0;
        @(negedge PCLK);
        bus0.req_valid = 2'b01; bus0.req_write = 2'b00; bus0.req_addr = '0; bus0.req_addr[31:0] = 32'h20;
        bus0.PREADY = 1'b0; bus0.PRDATA = 32'hCAFE_F00D;
        @(posedge PCLK); #1;
        vectors++;
        if (bus0.req_ready !== 2'b01) begin
            miscompares++; $display("FAIL nt_grant: got %b expected 01", bus0.req_ready);
        end
        for (int k = 1; k <= 100; k++) begin
            @(negedge PCLK); bus0.req_valid = '0;
            @(posedge PCLK); #1;
            if (bus0.rsp_valid !== '0) rsp_seen++;
            if ({bus0.PSELx, bus0.PENABLE} !== 2'b11) bus_bad++;
        end
        vectors++;
        if ({rsp_seen, bus_bad} !== {32'd0, 32'd0}) begin
            miscompares++; $display("FAIL nt_hold: got rsp %0d bus_bad %0d expected 0 0", rsp_seen, bus_bad);
        end
        @(negedge PCLK); bus0.PREADY = 1'b1;
        @(posedge PCLK); #1;
        vectors++;
        if ({bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata, bus0.PSELx} !== {2'b01, 1'b0, 32'hCAFE_F00D, 1'b0}) begin
            miscompares++; $display("FAIL nt_done: got %b %b %h %b expected 01 0 cafef00d 0",
                bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata, bus0.PSELx);
        end
    endtask

    task automatic test_reset_mid();
        int rsp_seen = 0;
        @(negedge PCLK);
        drive_req(1, 1'b1, 1'b1, 32'h30, 32'h7777_0000);
        bus.PREADY = 1'b0;
        @(posedge PCLK); #1;
        vectors++;
        if (bus.req_ready !== 3'b010) begin
            miscompares++; $display("FAIL rm_grant: got %b expected 010", bus.req_ready);
        end
        repeat (4) begin
            @(negedge PCLK); bus.req_valid = '0;
            @(posedge PCLK); #1;
        end
        #1 PRESETn = 1'b0;
        bus.PREADY = 1'b1;
        #1;
        vectors++;
        if ({bus.PSELx, bus.PENABLE, bus.busy, bus.PWRITE, bus.rsp_err, bus.req_ready, bus.rsp_valid,
             bus.PADDR, bus.PWDATA, bus.rsp_rdata} !== '0) begin
            miscompares++; $display("FAIL rm_async: got sel %b en %b busy %b addr %h wdata %h expected all 0",
                bus.PSELx, bus.PENABLE, bus.busy, bus.PADDR, bus.PWDATA);
        end
        repeat (2) begin
            @(posedge PCLK); #1;
            if (bus.rsp_valid !== '0) rsp_seen++;
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        drive_req(0, 1'b1, 1'b0, 32'h40, 32'h0);
        drive_req(1, 1'b1, 1'b0, 32'h44, 32'h0);
        drive_req(2, 1'b1, 1'b0, 32'h48, 32'h0);
        @(posedge PCLK); #1;
        vectors++;
        if ({bus.req_ready, bus.PADDR} !== {3'b001, 32'h40}) begin
            miscompares++; $display("FAIL rm_regrant: got %b %h expected 001 40", bus.req_ready, bus.PADDR);
        end
        @(negedge PCLK); bus.req_valid = '0;
        repeat (2) @(posedge PCLK);
        #1;
        if (bus.rsp_valid !== 3'b001 && bus.rsp_valid !== '0) rsp_seen++;
        vectors++;
        if ({rsp_seen, bus.rsp_valid} !== {32'd0, 3'b001}) begin
            miscompares++; $display("FAIL rm_no_stale: got stale %0d rv %b expected 0 001", rsp_seen, bus.rsp_valid);
        end
    endtask

    // Random traffic against a transaction-level model: a transfer occupies
    // the bus from its grant edge; its ACCESS samples begin one edge later
    // and it ends on the first PREADY=1 sample or on the WL-th low sample.
    task automatic test_random(int cycles);
        int ptr, owner, edges, stall, w;
        logic cur_wr, done, tmo, free;
        logic [NR-1:0] elig, exp_rr, exp_rv;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata, exp_rdata;
        logic exp_pwrite, exp_psel, exp_pen, exp_err;
        @(negedge PCLK);
        PRESETn = 1'b0; bus.req_valid = '0; bus.PREADY = 1'b1;
        @(negedge PCLK);
        PRESETn = 1'b1;
        ptr = 0; owner = -1; edges = 0; stall = 0; cur_wr = 1'b0;
        exp_rr = '0; exp_addr = '0; exp_wdata = '0; exp_pwrite = 1'b0; exp_psel = 1'b0; exp_pen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge PCLK);
            for (int i = 0; i < NR; i++) begin
                if (!bus.req_valid[i] || exp_rr[i]) begin
                    if ($urandom_range(0, 99) < 40)
                        drive_req(i, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
                    else
                        bus.req_valid[i] = 1'b0;
                end
            end
            if (stall > 0) begin
                bus.PREADY = 1'b0; stall--;
            end else begin
                bus.PREADY = ($urandom_range(0, 99) < 60);
                if ($urandom_range(0, 149) == 0) stall = $urandom_range(14, 20);
            end
            bus.PSLVERR = ($urandom_range(0, 4) == 0);
            bus.PRDATA  = $urandom;
            @(posedge PCLK);
            done = 1'b0; tmo = 1'b0;
            exp_rv = '0; exp_rr = '0; exp_rdata = '0; exp_err = 1'b0;
            if (owner >= 0 && edges >= 1) begin
                if (bus.PREADY) done = 1'b1;
                else if (edges == WL) tmo = 1'b1;
            end
            if (done || tmo) begin
                exp_rv[owner] = 1'b1;
                exp_err   = done ? bus.PSLVERR : 1'b1;
                exp_rdata = (done && !cur_wr) ? bus.PRDATA : '0;
            end
            free = (owner < 0) || done || tmo;
            elig = bus.req_valid;
            if (owner >= 0) elig[owner] = 1'b0;
            if (free && elig != '0) begin
                w = rr_pick(ptr, elig);
                ptr = (w + 1) % NR; owner = w; edges = 0;
                exp_rr[w]  = 1'b1;
                cur_wr     = bus.req_write[w];
                exp_pwrite = cur_wr;
                exp_addr   = bus.req_addr[w*AW +: AW];
                exp_wdata  = bus.req_wdata[w*DW +: DW];
                exp_psel   = 1'b1; exp_pen = 1'b0;
            end else if (free) begin
                owner = -1; exp_psel = 1'b0; exp_pen = 1'b0;
            end else begin
                edges++; exp_psel = 1'b1; exp_pen = 1'b1;
            end
            #1;
            vectors++;
            if ({bus.req_ready, bus.rsp_valid} !== {exp_rr, exp_rv}) begin
                miscompares++; $display("FAIL rnd_hs c%0d: got %b %b expected %b %b",
                    c, bus.req_ready, bus.rsp_valid, exp_rr, exp_rv);
            end
            vectors++;
            if ({bus.PSELx, bus.PENABLE, bus.busy} !== {exp_psel, exp_pen, exp_psel}) begin
                miscompares++; $display("FAIL rnd_ctl c%0d: got %b%b%b expected %b%b%b",
                    c, bus.PSELx, bus.PENABLE, bus.busy, exp_psel, exp_pen, exp_psel);
            end
            vectors++;
            if ({bus.PADDR, bus.PWDATA, bus.PWRITE} !== {exp_addr, exp_wdata, exp_pwrite}) begin
                miscompares++; $display("FAIL rnd_bus c%0d: got %h %h %b expected %h %h %b",
                    c, bus.PADDR, bus.PWDATA, bus.PWRITE, exp_addr, exp_wdata, exp_pwrite);
            end
            if (exp_rv != '0) begin
                vectors++;
                if ({bus.rsp_rdata, bus.rsp_err} !== {exp_rdata, exp_err}) begin
                    miscompares++; $display("FAIL rnd_rsp c%0d: got %h %b expected %h %b",
                        c, bus.rsp_rdata, bus.rsp_err, exp_rdata, exp_err);
                end
            end
        end
    endtask

    initial begin
        bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.PRDATA = '0; bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
        bus0.req_valid = '0; bus0.req_write = '0; bus0.req_addr = '0; bus0.req_wdata = '0;
        bus0.PRDATA = '0; bus0.PREADY = 1'b1; bus0.PSLVERR = 1'b0;
        test_reset();
        test_single_write();
        test_read_waits();
        test_round_robin();
        test_slave_error();
        test_timeout();
        test_no_timeout();
        test_reset_mid();
        test_random(4000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Shares one APB3 master port among NUM_REQ on-chip requesters (e.g. UVM-driven stimulus ports, DMA, CPU shim) in front of the APB UART slave. Arbitrates round-robin, sequences the APB SETUP/ACCESS phases, and returns read data or error to the granted requester. Bounds the wait-state count with a timeout so a hung slave cannot lock the bus.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters, 2..8.
- DATA_WIDTH, 32: APB data width.
- ADDR_WIDTH, 32: APB address width.
- WAIT_LIMIT, 16: max ACCESS cycles with PREADY=0 before forced error completion. 0 disables the timeout.

Ports:
- PCLK  in  1  bus clock; all logic on rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester transfer request; held until its req_ready pulse.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_ready  out  NUM_REQ  one-cycle grant pulse; request fields are captured.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owner.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR or timeout, valid with rsp_valid.
- busy  out  1  high in SETUP and ACCESS.
- PSELx, PENABLE, PWRITE  out  1 each  APB controls.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY, PSLVERR  in  1 each  APB slave handshake.

## Operation
- The FSM has three states: IDLE, SETUP, ACCESS. All outputs are registered.
- **IDLE:** if any req_valid=1, pick the winner, capture its write, addr, and wdata into the APB outputs, set PSELx=1 and PENABLE=0, pulse req_ready[winner], and go to SETUP.
- **SETUP:** unconditionally go to ACCESS with PENABLE=1. Clear the wait counter.
- **ACCESS:**
  - PREADY=1: sample PSLVERR, and PRDATA if it is a read. Pulse rsp_valid[owner]. Then:
    - If any req_valid=1, arbitrate and go directly to SETUP (back-to-back, no idle cycle), with PSELx held at 1 and PENABLE=0.
    - Otherwise go to IDLE with PSELx=0 and PENABLE=0.
  - PREADY=0: increment the wait counter. If WAIT_LIMIT!=0 and the counter reaches WAIT_LIMIT, complete with rsp_err=1 and rsp_rdata=0, then take the same next-state rule as above.
- **Arbitration:** round-robin. The pointer resets to 0. The winner is the first asserted req_valid at or above the pointer, wrapping around. After a grant to i, the pointer becomes (i+1) mod NUM_REQ.
- **Request handshake:**
  - req_valid of a requester already in flight is not considered until its rsp_valid has been issued. A requester may drop req_valid after its req_ready pulse.
  - A req_valid still high after rsp_valid is treated as a new transfer.
- **Idle bus state:** PADDR, PWDATA, and PWRITE hold their last values.
- **Reset:** PRESETn low at any time, including mid-transfer, asynchronously clears FSM to IDLE, pointer to 0, wait counter to 0, and every output to 0. The in-flight transfer is dropped with no rsp_valid.

## Timing
- Request sampled at edge E0 in IDLE: req_ready and PSELx are high E0–E1 (SETUP). PENABLE is high from E1 (ACCESS).
- PREADY=1 sampled at E2 gives rsp_valid high E2–E3. Minimum latency is request sampled to rsp_valid in 2 edges; APB throughput is 2 cycles per transfer back-to-back.
- Each wait state adds one cycle.
- Timeout fires at the edge where the wait counter equals WAIT_LIMIT, i.e. after WAIT_LIMIT ACCESS cycles with PREADY=0. PSELx and PENABLE drop after that edge.
- PSLVERR and PRDATA are ignored unless PREADY=1 in ACCESS.
- Simultaneous completion and new requests: the next grant happens at the completion edge. rsp_valid[old] and req_ready[new] are high in the same cycle.

## Test plan
- **Single write:** req 0 writes 0xA5A5_0001 to 0x0000_0004, PREADY=1 immediately. Expect PSELx for 2 cycles and PENABLE in the 2nd; PADDR=0x4 and PWDATA=0xA5A5_0001; one rsp_valid[0] with rsp_err=0.
- **Read with 3 wait states:** req 1 reads 0x8, PRDATA=0x1234_5678 with PREADY after 3 low cycles. Expect rsp_rdata=0x1234_5678, and rsp_valid 5 cycles after req_ready.
- **Round-robin:** both requesters hold req_valid continuously for 4 transfers. Expect grant order 0,1,0,1, back-to-back with PSELx never dropping, and PENABLE low exactly one cycle between transfers.
- **Slave error and timeout:**
  - PSLVERR=1 with PREADY: expect rsp_err=1.
  - WAIT_LIMIT=16 with PREADY held low: expect rsp_err=1, rsp_rdata=0, and PSELx=0 after 16 ACCESS cycles.
  - WAIT_LIMIT=0 with PREADY held low for 100 cycles: expect no completion.
- **Reset mid-ACCESS:** assert PRESETn=0 during wait states. Expect all outputs 0 immediately and no rsp_valid. After release, the first request is granted to requester 0 with the pointer back at 0.
